piso_serializer: RTL and testbench

Parallel-in, serial-out stage that sits directly upstream of the right_shift deserializer. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on sout, which drives right_shift input a. It emits LSB first by default, so after WIDTH shifts right_shift q equals the loaded word. It flags per-bit validity, the last bit of each frame, and busy status, and supports back-to-back frames with no gap cycle.

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_serializer_bit_counter.sv | 42 ++++
 rtl/piso_serializer.sv | 116 +++++++++++
 tb/tb_piso_serializer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the parallel-in/serial-out stage.
//   piso_state_t : two-state serializer FSM encoding.
//   cnt_w()      : bit-counter width for a given frame width.
package piso_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} piso_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter: modulo-WIDTH up-counter used to position bits within a frame.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (count -> 0)
//   clr_i     : load count to zero (wins over inc_i)
//   inc_i     : advance count; wraps WIDTH-1 -> 0
//   cnt_o     : current count
//   is_last_o : count is at WIDTH-1
module bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     inc_i,
  output logic [cnt_w(WIDTH)-1:0]  cnt_o,
  output logic                     is_last_o
);

  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign is_last_o = last;

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a WIDTH-bit word over valid/ready and emits it one
// bit per clock on sout (LSB first by default), feeding the downstream
// right-shift deserializer. A new word can be taken while the last bit of the
// current frame is on sout, so consecutive frames have no gap.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset; beats a same-cycle handshake
//   din        : parallel word, sampled only on accept
//   load_valid : upstream word present
//   load_ready : combinational; idle, or last bit of the frame on sout
//   sout       : registered serial bit
//   sout_valid : registered; sout carries a frame bit
//   frame_done : registered; last bit of a frame is on sout
//   busy       : registered; FSM is in SHIFT
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  piso_state_t      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic             sout_q, sout_valid_q, frame_done_q, busy_q;

  logic [CW-1:0]    cnt;
  logic             is_last;
  logic             accept;
  logic             first_bit;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    nxt_idx;
  logic             sout_d;

  assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && is_last);
  assign accept     = load_valid && load_ready;

  // Clear on accept; otherwise count every SHIFT cycle. At the last bit the
  // counter wraps to zero, which leaves it ready for the idle case too.
  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept),
    .inc_i     ((state_q == SHIFT) && !accept),
    .cnt_o     (cnt),
    .is_last_o (is_last)
  );

  assign first_bit = LSB_FIRST ? din[0] : din[WIDTH-1];
  assign cnt_inc   = cnt + CW'(1);

  // Index of the bit to present next cycle. At the last bit the index may
  // wrap, but that value is never used since the frame either ends or reloads.
  always_comb begin
    nxt_idx = cnt_inc;
    if (!LSB_FIRST) nxt_idx = CW'(WIDTH - 2) - cnt;
    sout_d = shreg_q[nxt_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else if (accept) begin
      // Same reload from IDLE or from the last bit of a frame.
      state_q      <= SHIFT;
      shreg_q      <= din;
      sout_q       <= first_bit;
      sout_valid_q <= 1'b1;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (!is_last) begin
            sout_q       <= sout_d;
            frame_done_q <= (cnt_inc == CW'(WIDTH - 1));
          end else begin
            state_q      <= IDLE;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          sout_q       <= 1'b0;
          sout_valid_q <= 1'b0;
          frame_done_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: WIDTH=4 LSB-first main instance with a
// small right-shift receiver model, plus WIDTH=8 MSB-first and WIDTH=2 instances.
module tb_piso_serializer;

  logic clk, rst;

  // WIDTH=4, LSB first
  logic [3:0] din4;
  logic       lv4, lr4, so4, sv4, fd4, bz4;
  // WIDTH=8, MSB first
  logic [7:0] din8;
  logic       lv8, lr8, so8, sv8, fd8, bz8;
  // WIDTH=2, LSB first
  logic [1:0] din2;
  logic       lv2, lr2, so2, sv2, fd2, bz2;

  logic [3:0] rs_q;  // downstream right-shift receiver: a enters at the MSB

  int n_chk  = 0;
  int n_fail = 0;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u4 (
    .clk(clk), .rst(rst), .din(din4), .load_valid(lv4), .load_ready(lr4),
    .sout(so4), .sout_valid(sv4), .frame_done(fd4), .busy(bz4));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u8 (
    .clk(clk), .rst(rst), .din(din8), .load_valid(lv8), .load_ready(lr8),
    .sout(so8), .sout_valid(sv8), .frame_done(fd8), .busy(bz8));

  piso_serializer #(.WIDTH(2), .LSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst(rst), .din(din2), .load_valid(lv2), .load_ready(lr2),
    .sout(so2), .sout_valid(sv2), .frame_done(fd2), .busy(bz2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rs_q <= {so4, rs_q[3:1]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample/drive 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic s, input logic v, input logic f);
    chk({tag, " sout"}, so4, s);
    chk({tag, " sout_valid"}, sv4, v);
    chk({tag, " frame_done"}, fd4, f);
  endtask

  task automatic chk_idle4(input string tag);
    chk4(tag, 1'b0, 1'b0, 1'b0);
    chk({tag, " busy"}, bz4, 1'b0);
    chk({tag, " load_ready"}, lr4, 1'b1);
  endtask

  initial begin
    logic [7:0] exp_a;
    logic [3:0] exp_b;
    rst = 1'b1;
    din4 = '0; lv4 = 1'b0;
    din8 = '0; lv8 = 1'b0;
    din2 = '0; lv2 = 1'b0;
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_idle4("reset");
    chk("reset u8 sout_valid", sv8, 1'b0);
    chk("reset u2 busy", bz2, 1'b0);

    // 1: single frame 1011 -> 1,1,0,1
    din4 = 4'b1011; lv4 = 1'b1;
    tick();
    lv4 = 1'b0; din4 = 4'b0000;
    exp_b = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk4($sformatf("t1 bit%0d", i), exp_b[i], 1'b1, i == 3);
      chk($sformatf("t1 busy%0d", i), bz4, 1'b1);
      tick();
    end
    chk_idle4("t1 end");
    chk("t1 rx q", rs_q, 4'b1011);

    // 2: back-to-back 1011 then 0110, no bubble
    din4 = 4'b1011; lv4 = 1'b1;
    tick();
    din4 = 4'b0110;
    exp_a = 8'b0110_1011;
    for (int i = 0; i < 8; i++) begin
      chk4($sformatf("t2 bit%0d", i), exp_a[i], 1'b1, (i == 3) || (i == 7));
      if (i == 0) chk("t2 ready mid", lr4, 1'b0);
      if (i == 3) chk("t2 ready last", lr4, 1'b1);
      if (i == 4) begin
        chk("t2 rx q frame1", rs_q, 4'b1011);
        lv4 = 1'b0;
      end
      tick();
    end
    chk_idle4("t2 end");
    chk("t2 rx q frame2", rs_q, 4'b0110);

    // 3: load_valid pulse mid-frame is ignored
    din4 = 4'b1100; lv4 = 1'b1;
    tick();
    lv4 = 1'b0;
    chk4("t3 bit0", 1'b0, 1'b1, 1'b0);
    tick();
    din4 = 4'b0011; lv4 = 1'b1;
    #1;
    chk("t3 ready cnt1", lr4, 1'b0);
    chk4("t3 bit1", 1'b0, 1'b1, 1'b0);
    tick();
    lv4 = 1'b0;
    chk4("t3 bit2", 1'b1, 1'b1, 1'b0);
    tick();
    chk4("t3 bit3", 1'b1, 1'b1, 1'b1);
    tick();
    chk_idle4("t3 end");
    tick();
    chk("t3 no restart", sv4, 1'b0);

    // 4: reset mid-frame, then clean 0101 -> 1,0,1,0
    din4 = 4'b1111; lv4 = 1'b1;
    tick();
    lv4 = 1'b0;
    chk4("t4 bit0", 1'b1, 1'b1, 1'b0);
    tick();
    chk4("t4 bit1", 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle4("t4 abort");
    din4 = 4'b0101; lv4 = 1'b1;
    tick();
    lv4 = 1'b0;
    exp_b = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      chk4($sformatf("t4 re bit%0d", i), exp_b[i], 1'b1, i == 3);
      tick();
    end
    chk_idle4("t4 end");
    chk("t4 rx q", rs_q, 4'b0101);

    // 6: rst and load_valid together -> word dropped
    din4 = 4'b1111; lv4 = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; lv4 = 1'b0;
    chk("t6 sout_valid", sv4, 1'b0);
    chk("t6 busy", bz4, 1'b0);
    tick();
    chk("t6 sout_valid next", sv4, 1'b0);
    chk("t6 sout next", so4, 1'b0);

    // 5: WIDTH=8 MSB first, A5 -> 1,0,1,0,0,1,0,1
    din8 = 8'hA5; lv8 = 1'b1;
    tick();
    lv8 = 1'b0; din8 = 8'h00;
    exp_a = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5 sout%0d", i), so8, exp_a[7-i]);
      chk($sformatf("t5 valid%0d", i), sv8, 1'b1);
      chk($sformatf("t5 done%0d", i), fd8, i == 7);
      tick();
    end
    chk("t5 end valid", sv8, 1'b0);
    chk("t5 end busy", bz8, 1'b0);

    // WIDTH=2 back-to-back: 10 then 01 -> 0,1,1,0, done on bits 2 and 4
    din2 = 2'b10; lv2 = 1'b1;
    tick();
    din2 = 2'b01;
    exp_b = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w2 sout%0d", i), so2, exp_b[3-i]);
      chk($sformatf("w2 valid%0d", i), sv2, 1'b1);
      chk($sformatf("w2 done%0d", i), fd2, (i == 1) || (i == 3));
      if (i == 2) lv2 = 1'b0;
      tick();
    end
    chk("w2 end valid", sv2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
